// File: rtl/nn_pkg.sv
// Shared types and helpers for the dense layer: FSM states, chain/accumulator
// sizing and the shift / ReLU / saturate output stage.
package nn_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} nn_state_e;

  function automatic int chain_len(input int num_inputs, input int num_neurons);
    return num_neurons * (num_inputs + 1);
  endfunction

  function automatic int acc_width(input int data_w, input int weights_w, input int num_inputs);
    return data_w + weights_w + $clog2(num_inputs + 1) + 1;
  endfunction

  // Accumulators are widened to 64 bits by the caller; only the low DataWidth bits are meaningful.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] acc, input int frac_bits,
                                                  input bit enable_relu, input int data_w);
    logic signed [63:0] r, hi, lo;
    r  = acc >>> frac_bits;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (enable_relu && r < 64'sd0) r = 64'sd0;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// One neuron: bias preload, one multiply-accumulate per cycle, and a result
// register loaded on the last input with the saturated/ReLU'd value.
module nn_mac_unit import nn_pkg::*; #(
  parameter int DataWidth    = 8,
  parameter int WeightsWidth = 8,
  parameter int AccWidth     = 20,
  parameter int FracBits     = 0,
  parameter int EnableRelu   = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    preload_i,
  input  logic                    mac_en_i,
  input  logic                    latch_i,
  input  logic [WeightsWidth-1:0] bias_i,
  input  logic [WeightsWidth-1:0] weight_i,
  input  logic [DataWidth-1:0]    actv_i,
  output logic [DataWidth-1:0]    res_o
);
  localparam int ProdW = DataWidth + WeightsWidth;

  logic signed [AccWidth-1:0] acc_q, acc_d, bias_ext;
  logic signed [ProdW-1:0]    prod;
  logic [DataWidth-1:0]       res_q, res_d;

  assign prod     = ProdW'($signed(actv_i)) * ProdW'($signed(weight_i));
  assign acc_d    = acc_q + AccWidth'(prod);
  assign bias_ext = AccWidth'($signed(bias_i)) <<< FracBits;
  // The last product is folded in combinationally so the result is ready as the FSM enters OUTPUT.
  assign res_d    = DataWidth'(sat_relu(64'(acc_d), FracBits, EnableRelu != 0, DataWidth));
  assign res_o    = res_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q <= '0;
      res_q <= '0;
    end else if (preload_i) begin
      acc_q <= bias_ext;
    end else if (mac_en_i) begin
      acc_q <= acc_d;
      if (latch_i) res_q <= res_d;
    end
  end

endmodule

// File: rtl/nn_dense_layer.sv
// Fully-connected layer: weight/bias scan chain, input/output handshakes and the
// IDLE/ACCUM/OUTPUT sequencer driving one MAC unit per neuron.
module nn_dense_layer import nn_pkg::*; #(
  parameter int NumInputs    = 4,
  parameter int NumNeurons   = 4,
  parameter int NumConsumers = 1,
  parameter int DataWidth    = 8,
  parameter int WeightsWidth = DataWidth,
  parameter int FracBits     = 0,
  parameter int EnableRelu   = 1,
  parameter int AccWidth     = acc_width(DataWidth, WeightsWidth, NumInputs)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             shift_i,
  input  logic [WeightsWidth-1:0]          scan_di,
  output logic [WeightsWidth-1:0]          scan_do,
  input  logic [DataWidth*NumInputs-1:0]   actv_i,
  input  logic                             req_i,
  output logic                             ack_o,
  output logic [DataWidth*NumNeurons-1:0]  actv_o,
  output logic                             req_o,
  input  logic [NumConsumers-1:0]          ack_i
);
  localparam int L    = chain_len(NumInputs, NumNeurons);
  localparam int IdxW = (NumInputs > 1) ? $clog2(NumInputs) : 1;

  logic [L-1:0][WeightsWidth-1:0]      chain_q;
  logic [NumInputs-1:0][DataWidth-1:0] actv_q;
  nn_state_e                           state_q;
  logic [IdxW-1:0]                     idx_q;
  logic [NumConsumers-1:0]             got_q;
  logic                                req_q;
  logic                                accept, mac_en, last;

  assign scan_do = chain_q[L-1];
  assign accept  = (state_q == IDLE) && req_i && !shift_i;
  assign ack_o   = accept;
  assign mac_en  = (state_q == ACCUM) && !shift_i;
  assign last    = (idx_q == IdxW'(NumInputs - 1));
  assign req_o   = req_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      chain_q <= '0;
    else if (shift_i) chain_q <= {chain_q[L-2:0], scan_di};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      actv_q  <= '0;
      idx_q   <= '0;
      got_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          actv_q  <= actv_i;
          idx_q   <= '0;
          got_q   <= '0;
          state_q <= ACCUM;
        end
        // Reloading weights mid-vector invalidates the partial sums, so drop the vector.
        ACCUM: if (shift_i) begin
          state_q <= IDLE;
        end else begin
          idx_q <= idx_q + 1'b1;
          if (last) begin
            state_q <= OUTPUT;
            req_q   <= 1'b1;
          end
        end
        OUTPUT: if (&(got_q | ack_i)) begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          got_q   <= '0;
        end else begin
          got_q <= got_q | ack_i;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar n = 0; n < NumNeurons; n++) begin : g_neuron
    logic [NumInputs-1:0][WeightsWidth-1:0] w_n;
    assign w_n = chain_q[n*(NumInputs+1) +: NumInputs];

    nn_mac_unit #(
      .DataWidth(DataWidth), .WeightsWidth(WeightsWidth), .AccWidth(AccWidth),
      .FracBits(FracBits), .EnableRelu(EnableRelu)
    ) u_mac (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .preload_i(accept),
      .mac_en_i (mac_en),
      .latch_i  (last),
      .bias_i   (chain_q[n*(NumInputs+1) + NumInputs]),
      .weight_i (w_n[idx_q]),
      .actv_i   (actv_q[idx_q]),
      .res_o    (actv_o[n*DataWidth +: DataWidth])
    );
  end

endmodule

// File: doc/nn_dense_layer.md
Name: nn_dense_layer

Overview:
Fully-connected neural layer with NumNeurons neurons. Each neuron time-multiplexes one MAC over NumInputs signed activations and adds a per-neuron bias. The result goes through an optional ReLU and saturates back to DataWidth. Weights and biases load through the standard word-wide scan chain (shift_i / scan_di / scan_do), so layers daisy-chain exactly like neuron instances. Inputs arrive on a req/ack handshake. Outputs leave on a req/ack handshake that joins acks from multiple downstream consumers.

Parameters:
NumInputs, 4, activations per input vector (>=1)
NumNeurons, 4, neurons in the layer (>=1)
NumConsumers, 1, downstream blocks that must each ack an output vector
DataWidth, 8, signed activation width
WeightsWidth, DataWidth, signed weight/bias width; also the scan word width
FracBits, 0, arithmetic right-shift applied to the accumulator before saturation
EnableRelu, 1, 1 = clamp negative results to 0; 0 = identity
AccWidth, DataWidth+WeightsWidth+$clog2(NumInputs+1)+1, accumulator width (derived; do not override)

Ports:
clk_i  input  1  clock
reset_i  input  1  asynchronous, active-high reset
shift_i  input  1  scan enable; shifts chain one word per cycle
scan_di  input  WeightsWidth  scan chain in
scan_do  output  WeightsWidth  scan chain out (last chain word)
actv_i  input  DataWidth*NumInputs  input vector; element k at [k*DataWidth +: DataWidth]
req_i  input  1  input vector valid; held until ack_o
ack_o  output  1  one-cycle pulse; vector captured
actv_o  output  DataWidth*NumNeurons  result vector; neuron n at [n*DataWidth +: DataWidth]
req_o  output  1  result valid; held until all consumers acked
ack_i  input  NumConsumers  per-consumer acknowledge

Behaviour:
- Chain length L = NumNeurons*(NumInputs+1) words.
  - Position p = n*(NumInputs+1)+k holds weight k of neuron n for k<NumInputs, and the bias of neuron n for k=NumInputs.
  - While shift_i=1, each cycle pos0<=scan_di and pos p<=pos p-1.
  - scan_do = pos L-1, combinational from the register.
  - The first word shifted in lands at L-1 after L shifts.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - req_i=1 and shift_i=0: capture actv_i, pulse ack_o for that cycle, set acc[n] = sign-extended bias[n] << FracBits, clear idx, go to ACCUM.
  - req_i=1 and shift_i=1: no capture, no ack.
- ACCUM, one cycle per input:
  - acc[n] += actv[idx]*w[n][idx], as a signed product sign-extended to AccWidth; idx++.
  - After idx=NumInputs-1, register the results and go to OUTPUT.
- Result per neuron: r = acc >>> FracBits.
  - If EnableRelu and r<0, r=0.
  - Saturate to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
- Latency: ack_o at cycle 0, ACCUM on cycles 1..NumInputs, req_o=1 from cycle NumInputs+1.
- OUTPUT:
  - req_o=1; actv_o stays stable until it returns to IDLE.
  - Sticky register got |= ack_i each cycle.
  - When (got | ack_i) is all ones, req_o deasserts on the next edge and the FSM returns to IDLE.
  - Each consumer's ack counts once per vector; repeated acks are harmless.
- No back-to-back overlap: a new req_i is accepted only from IDLE, i.e. no earlier than the cycle after req_o falls.
- shift_i asserted in ACCUM: the chain shifts and the FSM aborts to IDLE with no req_o and no output update.
- shift_i in OUTPUT: the chain shifts, the held result is unaffected, and the handshake completes normally.
- ack_i while not in OUTPUT is ignored.
- Reset values:
  - state IDLE; all chain words 0; acc, idx and got 0.
  - actv_o 0, req_o 0, ack_o 0; scan_do 0.
- Reset mid-operation discards everything, including loaded weights.

Decomposition:
- Package nn_pkg holds:
  - nn_state_e enum {IDLE, ACCUM, OUTPUT}
  - the function sat_relu(acc, FracBits, EnableRelu, DataWidth)
  - the L / AccWidth localparam helpers.
- Sub-module nn_mac_unit: one per neuron, holding the accumulator, bias preload and result stage.
- The chain registers and FSM live in nn_dense_layer.

Test Plan:
- Common configuration for the scenarios below: NumInputs=2, NumNeurons=2, FracBits=0.
- Load chain (neuron0 w=(2,3), b=1; neuron1 w=(-1,4), b=0), req_i with actv=(5,6) -> ack_o pulses at cycle 0; req_o at cycle 3 with actv_o=(29,19).
- Weights (127,127), b=0, actv=(127,127) -> result saturates to 127. With w=(-128,-128), EnableRelu=0 -> -128.
- neuron1 w=(-4,0), actv=(5,0) -> 0 with EnableRelu=1; -20 (0xEC) with EnableRelu=0.
- NumConsumers=2: ack_i[0] at t, ack_i[1] at t+3 -> req_o falls at t+4 and actv_o is stable throughout. ack_i=2'b11 in the first OUTPUT cycle -> req_o lasts one cycle.
- After a full load, shift L more words of zeros -> scan_do reproduces the loaded words in order, last-loaded word appearing last.
- shift_i raised in ACCUM -> no req_o, FSM back in IDLE. reset_i raised mid-OUTPUT -> req_o, actv_o and scan_do go to 0 immediately (asynchronously).
